// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOp codes, FSM encoding and the latched request record.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;
  localparam int unsigned OP_W = 3;

  // MemOp codes shared with the data memory and the controller
  localparam logic [OP_W-1:0] MEMOP_W  = 3'b000;
  localparam logic [OP_W-1:0] MEMOP_H  = 3'b001;
  localparam logic [OP_W-1:0] MEMOP_HU = 3'b010;
  localparam logic [OP_W-1:0] MEMOP_B  = 3'b011;
  localparam logic [OP_W-1:0] MEMOP_BU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [OP_W-1:0] op;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] pc;
  } lsu_req_t;

  // Expand byte enables to a bit mask so disabled lanes read as zero.
  function automatic logic [XLEN-1:0] be_mask(input logic [BE_W-1:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide req/gnt/rvalid data-memory port between the load/store unit and the data memory.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [BE_W-1:0] mem_be;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalignment and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic            misalign_c,
  output logic            valid_op_c,
  output logic [XLEN-1:0] rd_c
);

  logic [15:0] lane_h;
  logic [7:0]  lane_b;

  always_comb begin
    be_c       = '0;
    wdata_c    = '0;
    misalign_c = 1'b0;
    valid_op_c = 1'b1;
    rd_c       = '0;
    lane_h     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    lane_b     = rdata_i[7:0];

    case (addr_lo_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase

    case (op_i)
      MEMOP_W: begin
        be_c       = 4'b1111;
        wdata_c    = wd_i;
        misalign_c = (addr_lo_i != 2'd0);
        rd_c       = rdata_i;
      end
      MEMOP_H, MEMOP_HU: begin
        be_c       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{wd_i[15:0]}};
        misalign_c = addr_lo_i[0];
        rd_c       = (op_i == MEMOP_H) ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
      end
      MEMOP_B, MEMOP_BU: begin
        be_c    = BE_W'(4'b0001) << addr_lo_i;
        wdata_c = {4{wd_i[7:0]}};
        rd_c    = (op_i == MEMOP_B) ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
      end
      default: valid_op_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one access per request on a req/gnt/rvalid port, stalling the pipe until done.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [OP_W-1:0]   MemOp,
  input  logic [XLEN-1:0]   Addr,
  input  logic [XLEN-1:0]   PC,
  input  logic [XLEN-1:0]   DM_WD,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   DM_RD,
  output logic              exc_adel,
  output logic              exc_ades,
  load_store_unit_if.master mem
);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] dm_rd_q, dm_rd_d;
  logic            exc_adel_q, exc_adel_d;
  logic            exc_ades_q, exc_ades_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [BE_W-1:0] mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic [OP_W-1:0] align_op;
  logic [1:0]      align_addr_lo;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c;
  logic            misalign_c;
  logic            valid_op_c;
  logic [XLEN-1:0] rd_c;

  // Decode the incoming request while idle, the latched one afterwards (load extraction in WAIT).
  assign align_op      = (state_q == S_IDLE) ? MemOp      : req_q.op;
  assign align_addr_lo = (state_q == S_IDLE) ? Addr[1:0]  : req_q.addr_lo;

  lsu_align u_align (
    .op_i       (align_op),
    .addr_lo_i  (align_addr_lo),
    .wd_i       (DM_WD),
    .rdata_i    (mem.mem_rdata),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .misalign_c (misalign_c),
    .valid_op_c (valid_op_c),
    .rd_c       (rd_c)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    dm_rd_d     = dm_rd_q;
    exc_adel_d  = exc_adel_q;
    exc_ades_d  = exc_ades_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d       = '{we: req_we, op: MemOp, addr_lo: Addr[1:0], pc: PC};
          dm_rd_d     = '0;
          exc_adel_d  = 1'b0;
          exc_ades_d  = 1'b0;
          mem_be_d    = be_c;
          mem_addr_d  = {Addr[XLEN-1:2], 2'b00};
          mem_wdata_d = wdata_c;
          if (misalign_c) begin
            exc_adel_d = !req_we;
            exc_ades_d = req_we;
            state_d    = S_DONE;
          end else if (!valid_op_c) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_gnt) state_d = req_q.we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          dm_rd_d = rd_c;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status and request strobes are registered copies of the next state.
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    mem_req_d = (state_d == S_REQ);
    mem_we_d  = (state_d == S_REQ) && req_d.we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dm_rd_q     <= '0;
      exc_adel_q  <= 1'b0;
      exc_ades_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dm_rd_q     <= dm_rd_d;
      exc_adel_q  <= exc_adel_d;
      exc_ades_q  <= exc_ades_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign DM_RD         = dm_rd_q;
  assign exc_adel      = exc_adel_q;
  assign exc_ades      = exc_ades_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

`ifndef SYNTHESIS
  // Store log on the grant cycle; disabled lanes print as zero.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_REQ && req_q.we && mem.mem_gnt)
      $display("%d@%h: *%h <= %h", $time, req_q.pc, mem_addr_q, mem_wdata_q & be_mask(mem_be_q));
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan accesses plus random traffic against a lane-arithmetic model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  MemOp;
  logic [31:0] Addr;
  logic [31:0] PC;
  logic [31:0] DM_WD;
  logic        busy;
  logic        done;
  logic [31:0] DM_RD;
  logic        exc_adel;
  logic        exc_ades;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit_if mem_bus ();

  load_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .MemOp     (MemOp),
    .Addr      (Addr),
    .PC        (PC),
    .DM_WD     (DM_WD),
    .busy      (busy),
    .done      (done),
    .DM_RD     (DM_RD),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; 0 means the MemOp makes no access.
  function automatic int size_of(input logic [2:0] op);
    case (op)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] a);
    int sz = size_of(op);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    int sz = size_of(op);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r = r | (32'(8'(wd >> (8 * (i % sz)))) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rdata);
    logic [31:0] lane = rdata >> (8 * (a % 4));
    case (op)
      3'd1:    return (lane & 32'h8000) != 0 ? (lane | 32'hFFFF_0000) : (lane & 32'hFFFF);
      3'd2:    return lane & 32'hFFFF;
      3'd3:    return (lane & 32'h80) != 0 ? (lane | 32'hFFFF_FF00) : (lane & 32'hFF);
      3'd4:    return lane & 32'hFF;
      default: return rdata;
    endcase
  endfunction

  // Called at a negedge in an IDLE cycle; returns at a negedge in an IDLE cycle.
  task automatic run_access(input bit we, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            input int gd, input int rdl);
    int          sz     = size_of(op);
    bit          mis    = (sz > 0) && ((a % sz) != 0);
    bit          access = (sz > 0) && !mis;
    int          lat    = !access ? 1 : (we ? 2 + gd : 3 + gd + rdl);
    logic [31:0] exp_rd = (access && !we) ? model_load(op, a, rdata) : 32'd0;
    req_valid = 1'b1; req_we = we; MemOp = op; Addr = a; PC = $urandom; DM_WD = wd;
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'($urandom); MemOp = 3'($urandom); Addr = $urandom; DM_WD = $urandom;
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = $urandom;
      chk("busy", busy, 1);
      chk("done", done, (c == lat));
      chk("mem_req", mem_bus.mem_req, (access && c <= 1 + gd));
      if (access && c <= 1 + gd) begin
        chk("mem_we", mem_bus.mem_we, we);
        chk("mem_addr", mem_bus.mem_addr, a & 32'hFFFF_FFFC);
        chk("mem_be", mem_bus.mem_be, model_be(op, a));
        chk("mem_wdata", mem_bus.mem_wdata, model_wdata(op, wd));
        if (c == 1 + gd) mem_bus.mem_gnt = 1'b1;
        else             mem_bus.mem_rvalid = 1'($urandom);
      end
      if (access && !we && c == 2 + gd + rdl) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = rdata;
      end
      if (c == lat) begin
        chk("DM_RD", DM_RD, exp_rd);
        chk("exc_adel", exc_adel, mis && !we);
        chk("exc_ades", exc_ades, mis && we);
        mem_bus.mem_rvalid = 1'($urandom);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_mem_req", mem_bus.mem_req, 0);
    chk("held_DM_RD", DM_RD, exp_rd);
    chk("held_exc_adel", exc_adel, mis && !we);
    chk("held_exc_ades", exc_ades, mis && we);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_req"}, mem_bus.mem_req, 0);
    chk({tag, "_mem_we"}, mem_bus.mem_we, 0);
    chk({tag, "_mem_be"}, mem_bus.mem_be, 0);
    chk({tag, "_mem_addr"}, mem_bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_bus.mem_wdata, 0);
    chk({tag, "_DM_RD"}, DM_RD, 0);
    chk({tag, "_exc_adel"}, exc_adel, 0);
    chk({tag, "_exc_ades"}, exc_ades, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; MemOp = 3'd0; Addr = '0; PC = '0; DM_WD = '0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("reset");

    // Test-plan accesses
    run_access(1'b1, 3'd0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_access(1'b1, 3'd3, 32'h0000_1007, 32'h0000_00A5, 32'h0, 3, 0);
    run_access(1'b0, 3'd1, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 0, 0);
    run_access(1'b0, 3'd2, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 0, 0);
    run_access(1'b0, 3'd3, 32'h0000_1001, 32'h0, 32'h0000_F300, 0, 0);
    run_access(1'b0, 3'd0, 32'h0000_1002, 32'h0, 32'h1234_5678, 0, 0);
    run_access(1'b1, 3'd1, 32'h0000_1003, 32'h0000_BEEF, 32'h0, 0, 0);
    run_access(1'b0, 3'd6, 32'h0000_1000, 32'h0, 32'hFFFF_FFFF, 0, 0);

    // Reset while waiting for load data; late rvalid must be ignored.
    req_valid = 1'b1; req_we = 1'b0; MemOp = 3'd0; Addr = 32'h0000_2000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    chk("rst_wait_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("rst_mid_load");
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    chk("late_rvalid_done", done, 0);
    chk("late_rvalid_busy", busy, 0);
    chk("late_rvalid_DM_RD", DM_RD, 0);
    run_access(1'b0, 3'd0, 32'h0000_3000, 32'h0, 32'h0BAD_CAFE, 1, 2);

    // Reset while requesting a store: mem_req must drop.
    req_valid = 1'b1; req_we = 1'b1; MemOp = 3'd0; Addr = 32'h0000_4000; DM_WD = 32'h1111_2222;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_req_mem_req", mem_bus.mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("rst_mid_store");

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      run_access(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for data-memory accesses in the MIPS core. Accepts one load/store per transaction from the MEM stage and enforces halfword/word alignment. Each access becomes a single word-wide transaction with byte enables on a req/gnt/rvalid memory port. Returns sign- or zero-extended load data and holds the pipeline stalled until the access completes.

## Interface
- No parameters. The data memory is 32-bit wide and byte-addressed.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: access request from the MEM stage. It is sampled only while `busy`=0.
- `req_we` input 1: 1 selects a store, 0 selects a load.
- `MemOp` input 3: access size and extension. w=000, h=001, hu=010, b=011, bu=100.
- `Addr` input 32: byte address.
- `PC` input 32: PC of the requesting instruction. It is latched and used only by the store log.
- `DM_WD` input 32: store data, right-justified.
- `busy` output 1: high from the cycle after acceptance until `done`, inclusive.
- `done` output 1: one-cycle completion pulse.
- `DM_RD` output 32: extended load data. It is valid while `done`=1 and held until the next acceptance.
- `exc_adel` / `exc_ades` output 1: load/store address-error flags. They are valid with `done` and held until the next acceptance.
- `mem_req` output 1: memory request.
- `mem_we` output 1: memory write.
- `mem_be` output 4: byte enables; bit i corresponds to byte lane [8i+7:8i].
- `mem_addr` output 32: word-aligned address, {Addr[31:2],2'b00}.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_gnt` input 1: memory accepts the request in this cycle.
- `mem_rvalid` input 1: read data valid. It arrives no earlier than the cycle after `mem_gnt`.
- `mem_rdata` input 32: read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. `busy` = (state != IDLE).
- IDLE: when `req_valid`=1, latch req_we, MemOp, Addr, PC and DM_WD, and clear `DM_RD`, `exc_adel` and `exc_ades`. Then decode the request:
  - Misaligned (w with Addr[1:0]≠0, or h/hu with Addr[0]=1): set `exc_adel` (load) or `exc_ades` (store) and go to DONE. No memory access is made.
  - MemOp 101–111: go to DONE with no access and no exception; `DM_RD`=0.
  - Otherwise go to REQ.
- REQ: assert `mem_req` together with the decoded `mem_we`, `mem_be`, `mem_addr` and `mem_wdata`. These are held stable until `mem_gnt`=1. On grant:
  - a store goes to DONE;
  - a load goes to WAIT.
- WAIT: on `mem_rvalid`, register the extracted `DM_RD` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Byte enables:
  - w: 1111.
  - h/hu: 0011 if Addr[1]=0, else 1100.
  - b/bu: 0001<<Addr[1:0].
- Store data: w = DM_WD; h = {2{DM_WD[15:0]}}; b = {4{DM_WD[7:0]}}.
- Load extraction: take the lane of `mem_rdata` selected by Addr[1:0]. h and b sign-extend from the top bit of the lane; hu and bu zero-extend; w passes through.
- On the store grant cycle, display "%d@%h: *%h <= %h" with $time, latched PC, `mem_addr`, and `mem_wdata` masked by `mem_be` (disabled lanes shown as 0).
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset: state=IDLE. `busy`, `done`, `mem_req`, `mem_we`, `exc_adel` and `exc_ades` are 0; `mem_be`=0, and `DM_RD`, `mem_addr` and `mem_wdata` are 0.
- Reset mid-transaction: everything returns to IDLE on the next edge, `mem_req` drops that cycle, and a late `mem_rvalid` is ignored.
- `req_valid` is accepted at edge T0. REQ occupies cycle 1.
- Store with immediate grant: `done` in cycle 2.
- Load with grant in cycle 1 and `mem_rvalid` in cycle 2: `done` in cycle 3.
- Exception or invalid MemOp: `done` in cycle 1, and `mem_req` never rises.
- Each stall cycle (no `mem_gnt`, no `mem_rvalid`) adds exactly one cycle of latency.
- `req_valid` asserted while `busy`=1 is dropped. The MEM stage holds it until it sees `done`.
- Back-to-back: a request presented in the DONE cycle is not accepted; one presented in the following cycle (IDLE) is.

## Structure
- Package `lsu_pkg`:
  - MemOp constants (w, h, hu, b, bu), shared with the data memory and the controller.
  - FSM state encoding.
- Sub-module `lsu_align`: purely combinational. It computes `mem_be`, `mem_wdata`, misalignment, and load extraction/extension from MemOp, Addr[1:0], DM_WD and `mem_rdata`.
- The FSM, request latches and log statement live in `load_store_unit`.

## Test plan
- **sw word store:** sw, Addr=0x0000_1004, DM_WD=0xDEADBEEF, `mem_gnt` held in the REQ cycle. Expect `mem_be`=1111, `mem_addr`=0x1004, `done` 2 cycles after acceptance, log "…: *00001004 <= deadbeef".
- **sb byte store:** sb, Addr=0x1007, DM_WD=0x0000_00A5, `mem_gnt` delayed 3 cycles. Expect `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, request lines stable across the stall, `done` in cycle 5.
- **lh/lhu halfword loads:** lh at Addr=0x1002 with `mem_rdata`=0x8001_7FFF, then lhu at the same address. Expect `DM_RD`=0xFFFF_8001 for lh and 0x0000_8001 for lhu, each with `done` 3 cycles after acceptance.
- **lb byte load:** lb at Addr=0x1001 with `mem_rdata`=0x0000_F300. Expect `DM_RD`=0xFFFF_FFF3.
- **misaligned accesses:** lw at Addr=0x1002 and sh at Addr=0x1003. Expect `exc_adel`=1 and `exc_ades`=1 respectively, `done` in cycle 1, and `mem_req` never asserted.
- **reset mid-load:** reset asserted during WAIT, then `mem_rvalid` pulses afterwards. Expect all outputs 0 after the edge, no `done`, and a new lw accepted normally.
